// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
//   arb_state_t         : arbiter FSM states
//   HALT_OPCODE_DEFAULT : instruction word that stops instruction fetch
//   STALL_CNT_W         : width of the fetch stall counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } arb_state_t;

  localparam logic [15:0] HALT_OPCODE_DEFAULT = 16'hF000;
  localparam int          STALL_CNT_W         = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and a
// single-port synchronous memory.
//   Fetch : if_req, if_addr -> if_ack, if_rdata
//   Data  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata
//   Memory: mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//           (mem_rdata is valid the cycle after an enabled read)
// Modports:
//   master : the requester/memory side of the bus
//   slave  : the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requests, with a starvation
// counter that forces a fetch grant after STARVE_LIMIT consecutive data
// grants taken while a fetch was waiting.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_grant_ok : arbiter is able to issue an access this cycle
//   i_if_req   : raw fetch request (drives the starvation count)
//   i_if_elig  : fetch request that may actually be granted
//   i_d_req    : data request
//   o_gnt_if   : fetch granted this cycle
//   o_gnt_d    : data granted this cycle
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_grant_ok,
  input  logic i_if_req,
  input  logic i_if_elig,
  input  logic i_d_req,
  output logic o_gnt_if,
  output logic o_gnt_d
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;
  logic          w_starved;

  assign w_starved = (r_starve == LIMIT);

  // Data wins a collision unless fetch has been passed over LIMIT times.
  always_comb begin
    o_gnt_if = 1'b0;
    o_gnt_d  = 1'b0;
    if (i_grant_ok) begin
      if (i_d_req && !(i_if_elig && w_starved)) begin
        o_gnt_d = 1'b1;
      end else if (i_if_elig) begin
        o_gnt_if = 1'b1;
      end
    end
  end

  // Starvation counter: counts data grants that a waiting fetch lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (o_gnt_if) begin
      r_starve <= '0;
    end else if (o_gnt_d) begin
      if (!i_if_req) begin
        r_starve <= '0;
      end else if (!w_starved) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between an instruction-fetch
// port and a load/store data port. One access is issued from IDLE, the
// next cycle is spent in a WAIT state delivering the ack and read data,
// so throughput is one access per two cycles. Fetching a HALT_OPCODE word
// sets a sticky halt that blocks further fetches; data keeps being served.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : mem_arbiter_if.slave (fetch, data and memory signals)
//   halted       : sticky halt flag, cleared only by rst
//   if_stall_cnt : saturating count of cycles a fetch waited ungranted
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int              ADDR_W       = 16,
  parameter int              DATA_W       = 16,
  parameter int              STARVE_LIMIT = 4,
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(HALT_OPCODE_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_arbiter_if.slave           bus,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] if_stall_cnt
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(
    input logic [STALL_CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_grant_ok;
  logic              w_if_elig;
  logic              w_gnt_if;
  logic              w_gnt_d;
  logic              w_if_ack;
  logic              w_d_ack;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              r_d_we_p1;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_halted;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Issue is only possible from IDLE, and never while reset is asserted.
  assign w_grant_ok = (r_state == IDLE) && !rst;
  assign w_if_elig  = bus.if_req && !r_halted;

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .i_grant_ok (w_grant_ok),
    .i_if_req   (bus.if_req),
    .i_if_elig  (w_if_elig),
    .i_d_req    (bus.d_req),
    .o_gnt_if   (w_gnt_if),
    .o_gnt_d    (w_gnt_d)
  );

  // ---- stage p0: issue to memory (combinational from the granted port)
  assign w_mem_addr    = w_gnt_if ? bus.if_addr : bus.d_addr;
  assign bus.mem_en    = w_gnt_if | w_gnt_d;
  assign bus.mem_we    = w_gnt_d & bus.d_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = bus.d_wdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_if) begin
          w_state_nxt = WAIT_IF;
        end else if (w_gnt_d) begin
          w_state_nxt = WAIT_D;
        end
      end
      WAIT_IF: w_state_nxt = IDLE;
      WAIT_D:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Direction of the outstanding data access, needed at ack time.
  always_ff @(posedge clk) begin
    if (w_gnt_d) begin
      r_d_we_p1 <= bus.d_we;
    end
  end

  // ---- stage p1: ack and read data return
  // Reset during WAIT drops the ack outright; a write already issued stays.
  assign w_if_ack = (r_state == WAIT_IF) && !rst;
  assign w_d_ack  = (r_state == WAIT_D) && !rst;

  // Read data passes straight through on the ack cycle and is held after.
  assign bus.if_ack   = w_if_ack;
  assign bus.if_rdata = w_if_ack ? bus.mem_rdata : r_if_rdata;
  assign bus.d_ack    = w_d_ack;
  assign bus.d_rdata  = (w_d_ack && !r_d_we_p1) ? bus.mem_rdata : r_d_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_if_ack) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_d_ack && !r_d_we_p1) begin
        r_d_rdata <= bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_if_ack && (bus.mem_rdata == HALT_OPCODE)) begin
      r_halted <= 1'b1;
    end
  end

  // WAIT cycles with a fetch pending count as stall too; a halted core
  // is not considered stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (bus.if_req && !w_gnt_if && !r_halted) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign halted       = r_halted;
  assign if_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural single-port memory, one
// arbiter with STARVE_LIMIT=4 for the functional sequences and a second
// one with a huge STARVE_LIMIT for stall-counter saturation.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic        halted;
  logic        halted2;
  logic [15:0] stall;
  logic [15:0] stall2;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus  ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .halted       (halted),
    .if_stall_cnt (stall)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(70000)) dut2 (
    .clk          (clk),
    .rst          (rst2),
    .bus          (bus2),
    .halted       (halted2),
    .if_stall_cnt (stall2)
  );

  // Memory model: read data appears the cycle after an enabled read.
  logic [15:0] mem [0:65535];
  logic [15:0] mem_rd;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rd <= mem[bus.mem_addr];
    end
  end

  assign bus.mem_rdata  = mem_rd;
  assign bus2.mem_rdata = 16'h0000;

  int   n_run  = 0;
  int   n_fail = 0;
  logic exp_if;
  logic seen;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    bus2.if_req = 1; bus2.if_addr = '0; bus2.d_req = 1; bus2.d_we = 0;
    bus2.d_addr = '0; bus2.d_wdata = '0;

    step();
    preload(16'h0010, 16'h1234);
    preload(16'h0020, 16'hF000);
    preload(16'h0030, 16'h5555);

    // Reset state, with a fetch request already present
    bus.if_req = 1; bus.if_addr = 16'h0010;
    #1;
    check("rst_mem_en",   bus.mem_en,   0);
    check("rst_if_ack",   bus.if_ack,   0);
    check("rst_d_ack",    bus.d_ack,    0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata",  bus.d_rdata,  0);
    check("rst_halted",   halted,       0);
    step();
    check("rst_stall", stall, 0);

    // Single fetch
    rst = 1'b0;
    #1;
    check("f_issue", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 16'h0010});
    step();
    check("f_ack",    bus.if_ack,   1);
    check("f_rdata",  bus.if_rdata, 16'h1234);
    check("f_wait_en", bus.mem_en,  0);
    bus.if_req = 0;
    step();
    check("f_ack_low",  bus.if_ack,   0);
    check("f_rdata_hold", bus.if_rdata, 16'h1234);
    check("f_stall",    stall,        0);

    // Store then load
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0100; bus.d_wdata = 16'hBEEF;
    #1;
    check("st_issue", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
          {2'b11, 16'h0100, 16'hBEEF});
    step();
    check("st_ack",   bus.d_ack,   1);
    check("st_rdata", bus.d_rdata, 0);
    bus.d_req = 0;
    step();
    check("st_ack_low", bus.d_ack, 0);
    bus.d_req = 1; bus.d_we = 0;
    #1;
    check("ld_issue", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 16'h0100});
    step();
    check("ld_ack",   bus.d_ack,   1);
    check("ld_rdata", bus.d_rdata, 16'hBEEF);
    bus.d_req = 0;
    step();
    check("ld_rdata_hold", {bus.d_ack, bus.d_rdata}, {1'b0, 16'hBEEF});

    // Starvation: both held, expect D,D,D,D,IF,D
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0100;
    bus.if_req = 1; bus.if_addr = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      exp_if = (i == 4);
      #1;
      check($sformatf("starve_gnt%0d", i), {bus.mem_en, bus.mem_addr},
            {1'b1, exp_if ? 16'h0030 : 16'h0100});
      if (i == 4) check("starve_stall", stall, 8);
      step();
      if (exp_if) begin
        check("starve_if_ack", {bus.if_ack, bus.if_rdata}, {1'b1, 16'h5555});
        bus.if_req = 0;
      end else begin
        check($sformatf("starve_d_ack%0d", i), {bus.d_ack, bus.d_rdata},
              {1'b1, 16'hBEEF});
      end
      if (i == 5) bus.d_req = 0;
      step();
    end
    check("starve_stall_hold", stall, 8);

    // Halt: fetch of HALT word, later fetches ignored, data still served
    bus.if_req = 1; bus.if_addr = 16'h0020;
    #1;
    check("h_issue", {bus.mem_en, bus.mem_addr}, {1'b1, 16'h0020});
    step();
    check("h_ack", {bus.if_ack, bus.if_rdata}, {1'b1, 16'hF000});
    check("h_not_yet", halted, 0);
    step();
    check("h_halted", halted, 1);
    check("h_stall", stall, 9);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0100;
    #1;
    check("h_d_issue", {bus.mem_en, bus.mem_addr}, {1'b1, 16'h0100});
    step();
    check("h_d_ack", {bus.d_ack, bus.d_rdata, bus.if_ack}, {1'b1, 16'hBEEF, 1'b0});
    bus.d_req = 0;
    seen = 1'b0;
    repeat (6) begin
      step();
      seen = seen | bus.if_ack | bus.mem_en;
    end
    check("h_no_fetch", seen, 0);
    check("h_stall_frozen", {halted, stall}, {1'b1, 16'd9});
    bus.if_req = 0;

    // Reset during WAIT_D of a write
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'hCAFE;
    #1;
    check("r_issue", {bus.mem_en, bus.mem_we}, 2'b11);
    step();
    rst = 1'b1;
    #1;
    check("r_no_ack", {bus.d_ack, bus.mem_en}, 0);
    step();
    rst = 1'b0; bus.d_req = 0; bus.d_we = 0;
    #1;
    check("r_acks",   {bus.d_ack, bus.if_ack, bus.mem_en}, 0);
    check("r_rdata",  {bus.if_rdata, bus.d_rdata}, 0);
    check("r_status", {halted, stall}, 0);
    bus.d_req = 1; bus.d_addr = 16'h0200;
    #1;
    check("r_ld_issue", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 16'h0200});
    step();
    check("r_committed", {bus.d_ack, bus.d_rdata}, {1'b1, 16'hCAFE});
    bus.d_req = 0;
    step();
    bus.if_req = 1; bus.if_addr = 16'h0010;
    step();
    check("r_fetch_again", {bus.if_ack, bus.if_rdata}, {1'b1, 16'h1234});
    bus.if_req = 0;

    // Stall counter saturation on the second arbiter
    check("sat_rst", stall2, 0);
    rst2 = 1'b0;
    repeat (100) step();
    check("sat_100", stall2, 100);
    repeat (65434) step();
    check("sat_fffe", stall2, 16'hFFFE);
    step();
    check("sat_ffff", stall2, 16'hFFFF);
    repeat (20) step();
    check("sat_hold", {halted2, stall2}, {1'b0, 16'hFFFF});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory and instruction word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive data grants while a fetch waits.
REQ-004 SHALL have parameter HALT_OPCODE, default 16'hF000, instruction word that halts fetch.
REQ-005 SHALL provide port clk  in  1  single clock; all logic on posedge.
REQ-006 SHALL provide port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL provide ports if_req in 1 fetch request; if_addr in ADDR_W fetch address; if_ack out 1 fetch complete; if_rdata out DATA_W fetched word.
REQ-008 SHALL provide ports d_req in 1 data request; d_we in 1 write when high; d_addr in ADDR_W; d_wdata in DATA_W; d_ack out 1 data complete; d_rdata out DATA_W load data.
REQ-009 SHALL provide ports mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid the cycle after an enabled read.
REQ-010 SHALL provide ports halted out 1 sticky halt flag; if_stall_cnt out 16 saturating count of fetch wait cycles.

Function
REQ-011 SHALL share one single-port memory between the fetch port and the data port, with at most one access issued per cycle.
REQ-012 SHALL implement states IDLE, WAIT_IF, WAIT_D; IDLE with grant -> WAIT_IF or WAIT_D; either WAIT state -> IDLE unconditionally.
REQ-013 SHALL, in IDLE with an eligible request, drive mem_en=1 and mem_addr/mem_we/mem_wdata combinationally from the granted port in the same cycle.
REQ-014 SHALL drive mem_en=0 in WAIT states and whenever rst is high.
REQ-015 SHALL pulse the granted port's ack for exactly one cycle, the cycle after issue (latency 1), passing mem_rdata through to that port's rdata.
REQ-016 SHALL hold d_rdata at its previous value on write acks.
REQ-017 SHALL hold if_rdata/d_rdata stable when the corresponding ack is low.
REQ-018 SHALL require requesters to hold req and request fields stable until ack; a req still high in the IDLE cycle after ack is a new request.
REQ-019 SHALL, when both requests are pending, grant data, unless the starvation counter equals STARVE_LIMIT, in which case it grants fetch.
REQ-020 SHALL increment the starvation counter on a data grant with if_req high, clear it on any fetch grant or on a data grant with if_req low, and saturate it at STARVE_LIMIT.
REQ-021 SHALL set halted on the cycle after a fetch ack whose if_rdata equals HALT_OPCODE; halted SHALL stay set until rst.
REQ-022 SHALL, while halted, never grant fetch (if_ack stays 0) and continue serving the data port.
REQ-023 SHALL increment if_stall_cnt on every cycle with if_req high, no fetch grant and not halted, saturating at 16'hFFFF.
REQ-024 SHALL throttle throughput to one access per two cycles; back-to-back grants to the same port are allowed.

Reset
REQ-025 SHALL, on a clock edge with rst high, force state IDLE, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, halted=0, starvation counter=0, if_stall_cnt=0.
REQ-026 SHALL, on rst during a WAIT state, drop the pending ack (never delivered); a write already issued to memory stays committed.

Structure
REQ-027 SHALL place the state enum and the default HALT_OPCODE constant in shared package mem_arb_pkg.
REQ-028 SHALL isolate grant selection and the starvation counter in sub-module mem_arb_prio; the FSM, halt and stall logic stay in mem_arbiter.

Verification
REQ-029 SHALL check single fetch: if_req=1, if_addr=16'h0010, mem word 16'h1234 -> mem_en and mem_addr=16'h0010 in issue cycle N; if_ack=1 and if_rdata=16'h1234 in cycle N+1.
REQ-030 SHALL check store then load: d_we=1, d_addr=16'h0100, d_wdata=16'hBEEF, then a load of 16'h0100 -> d_ack each after 1 cycle, load d_rdata=16'hBEEF.
REQ-031 SHALL check starvation: d_req and if_req held continuously -> grant order D,D,D,D,IF,D,... with STARVE_LIMIT=4; if_stall_cnt=8 at the first fetch grant.
REQ-032 SHALL check halt: fetch returns 16'hF000 -> halted=1 the cycle after ack; later fetch requests get no ack; a concurrent d_req still completes.
REQ-033 SHALL check reset mid-operation: rst asserted in WAIT_D of a write -> no d_ack, memory holds the written value, all outputs at reset values the next cycle.
REQ-034 SHALL check that if_stall_cnt saturates at 16'hFFFF under sustained data traffic with fetch starvation disabled by STARVE_LIMIT=65535 or more.
